// File: rtl/fp_pkg.sv
// Shared widths, constants and FSM state encoding for the FP normalise/pack path.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/fp_pack_word.sv
// Combinational packer: builds the IEEE-754 word from the working fields and the result flag.
module fp_pack_word #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               sign_i,
  input  logic [EXP_W-1:0]   exp_i,
  input  logic [MAN_W-1:0]   frac_i,
  input  logic               zero_i,
  input  logic               ovf_i,
  input  logic               unf_i,
  output logic [EXP_W+MAN_W:0] word_o
);

  // Special results override the fields; zero is always +0.
  always_comb begin
    word_o = {sign_i, exp_i, frac_i};
    if (zero_i) begin
      word_o = '0;
    end else if (ovf_i) begin
      word_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf_i) begin
      word_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Normalises a raw adder result (carry right-shift or iterative left-shift) and packs it.
module fp_norm_pack #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [MAN_W:0]       in_mant,
  input  logic                 in_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_word,
  output logic                 out_zero,
  output logic                 out_ovf,
  output logic                 out_unf
);

  import fp_pkg::*;

  localparam logic [EXP_W-1:0] ExpAllOnes = '1;
  localparam logic [EXP_W:0]   ExpOne     = 1;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic [MAN_W:0]     mant_q, mant_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [EXP_W:0]     expInc;
  logic [EXP_W:0]     expDec;
  logic [MAN_W:0]     mantSh;

  assign expInc = {1'b0, in_exp} + ExpOne;
  assign expDec = exp_q - ExpOne;
  assign mantSh = {mant_q[MAN_W-1:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // SHIFT looks one step ahead so a result that becomes normal lands in DONE on the same edge.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = DONE;
          if (in_carry) begin
            mant_d = {1'b1, in_mant[MAN_W:1]};
            exp_d  = expInc;
          end
          if (in_exp == ExpAllOnes || (in_carry && expInc == {1'b0, ExpAllOnes})) begin
            ovf_d = 1'b1;
          end else if (!in_carry && in_mant == '0) begin
            zero_d = 1'b1;
          end else if (!in_carry && in_exp == '0) begin
            unf_d = 1'b1;
          end else if (!in_carry && !in_mant[MAN_W]) begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (exp_q <= ExpOne) begin
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = mantSh;
          exp_d  = expDec;
          if (mantSh[MAN_W] || expDec == ExpOne) begin
            unf_d   = !mantSh[MAN_W];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

  fp_pack_word #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_pack (
    .sign_i(sign_q),
    .exp_i (exp_q[EXP_W-1:0]),
    .frac_i(mant_q[MAN_W-1:0]),
    .zero_i(zero_q),
    .ovf_i (ovf_q),
    .unf_i (unf_q),
    .word_o(out_word)
  );

endmodule

// File: tb/tb_fp_norm_pack.sv
// Vector table plus scoreboard for fp_norm_pack, with reset-abort and output-hold sequences.
module tb_fp_norm_pack;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        carry;
    logic [31:0] word;
    logic        z;
    logic        o;
    logic        u;
    int          shifts;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        z;
    logic        o;
    logic        u;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        in_carry = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   lastLat = 0;
  exp_t sbQ[$];
  vec_t vecs[13];

  fp_norm_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one input, records its expectation, then waits (bounded) for out_valid.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    in_carry = v.carry;
    e.word = v.word;
    e.z    = v.z;
    e.o    = v.o;
    e.u    = v.u;
    e.lat  = 1 + v.shifts;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lastLat  = 1;
    while (!out_valid && lastLat < 60) begin
      @(posedge clk);
      #1;
      lastLat++;
    end
    check("out_valid_arrives", out_valid, 1);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sbQ.pop_front();
      check("out_word", out_word, e.word);
      check("out_zero", out_zero, e.z);
      check("out_ovf", out_ovf, e.o);
      check("out_unf", out_unf, e.u);
      check("latency", lastLat, e.lat);
      check("in_ready_in_done", in_ready, 0);
    end
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{1'b0, 8'h81, 24'hC00000, 1'b0, 32'h40C00000, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 8'h80, 24'h800000, 1'b1, 32'h40C00000, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 8'h85, 24'h000001, 1'b0, 32'h37000000, 1'b0, 1'b0, 1'b0, 23};
    vecs[3]  = '{1'b1, 8'h10, 24'h000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 8'hFE, 24'h800000, 1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 0};
    vecs[5]  = '{1'b1, 8'hFF, 24'h900000, 1'b0, 32'hFF800000, 1'b0, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b1, 8'h00, 24'h400000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 0};
    vecs[7]  = '{1'b0, 8'h03, 24'h100000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 2};
    vecs[8]  = '{1'b1, 8'h81, 24'h400000, 1'b0, 32'hC0000000, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b0, 8'h7F, 24'hFFFFFF, 1'b1, 32'h407FFFFF, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 8'h02, 24'h400000, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b0, 8'hFD, 24'h800000, 1'b1, 32'h7F400000, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{1'b1, 8'hFE, 24'hFFFFFF, 1'b0, 32'hFF7FFFFF, 1'b0, 1'b0, 1'b0, 0};

    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_word", out_word, 0);
    check("reset_flags", {out_zero, out_ovf, out_unf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
      releaseOutput();
    end

    // Hold the underflow result for three cycles while offering a new input that must be ignored.
    applyStimulus(vecs[7]);
    checkOutput();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = 1'b1;
      in_exp   = 8'h90;
      in_mant  = 24'hA00000;
      in_carry = 1'b0;
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_out_word", out_word, 32'h00000000);
      check("hold_out_unf", out_unf, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    releaseOutput();
    applyStimulus(vecs[0]);
    checkOutput();
    releaseOutput();

    // Reset in the middle of the long shift sequence abandons the result.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h85;
    in_mant  = 24'h000001;
    in_carry = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("shift_in_ready_low", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_word", out_word, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("abort_no_out_valid", pulses, 0);
    applyStimulus(vecs[8]);
    checkOutput();
    releaseOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fp_norm_pack.md
FP_NORM_PACK -- requirements
Module: fp_norm_pack

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width (significand is MAN_W+1 bits).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  raw adder result present.
REQ-006 in_ready  output  1  block can accept; equals (state==IDLE).
REQ-007 in_sign  input  1  result sign from the adder.
REQ-008 in_exp  input  EXP_W  biased exponent before normalisation.
REQ-009 in_mant  input  MAN_W+1  significand, hidden bit at MSB position.
REQ-010 in_carry  input  1  significand carry-out from the adder.
REQ-011 out_valid  output  1  packed word valid; equals (state==DONE).
REQ-012 out_ready  input  1  consumer accepts out_word.
REQ-013 out_word  output  1+EXP_W+MAN_W  IEEE-754 word {sign, exp, fraction}.
REQ-014 out_zero, out_ovf, out_unf  output  1 each  result flags, valid with out_valid.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-016 Accept on rising edge when in_valid && in_ready; capture sign, exp, mant, carry into working registers.
REQ-017 On accept with in_carry=1: mant <= {1, in_mant[MAN_W:1]} (truncate), exp <= in_exp+1; if in_exp+1 == all-ones -> overflow; go DONE.
REQ-018 On accept with in_exp == all-ones: overflow; go DONE.
REQ-019 On accept with in_carry=0 and in_mant==0: zero; go DONE.
REQ-020 On accept with in_carry=0, in_mant!=0, in_exp==0: underflow; go DONE.
REQ-021 On accept with in_mant MSB=1 and no other case: go DONE (latency 1 cycle).
REQ-022 Otherwise go SHIFT; each SHIFT cycle: if mant MSB=1 -> DONE; else if exp==1 -> underflow, DONE; else mant <<= 1, exp -= 1.
REQ-023 Latency accept-edge to out_valid SHALL be 1+k cycles, k = left shifts performed (k <= MAN_W).
REQ-024 Normal result: out_word = {sign, exp, mant[MAN_W-1:0]}, all flags 0.
REQ-025 Zero result: out_word = all zeros (+0, sign forced 0), out_zero=1.
REQ-026 Overflow: out_word = {sign, all-ones, 0}, out_ovf=1.
REQ-027 Underflow: out_word = {sign, 0, 0} (flush), out_unf=1.
REQ-028 At most one flag SHALL be set per result.
REQ-029 In DONE, out_word and flags SHALL hold stable until out_ready=1; on that edge go IDLE.
REQ-030 in_ready=0 in SHIFT and DONE; no input captured there; back-to-back throughput one result per 2+k cycles.
REQ-031 Exponent arithmetic SHALL use EXP_W+1 bits internally to detect increment overflow.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, working registers 0, out_word 0, all flags 0, out_valid 0.
REQ-033 While in reset and after release, in_ready=1 (IDLE); first accept no earlier than first edge with rst_n=1.
REQ-034 Reset asserted in SHIFT or DONE SHALL abandon the in-flight result with no out_valid pulse.

Structure
REQ-035 Shared package fp_pkg SHALL hold EXP_W, MAN_W, BIAS=127, EXP_MAX=all-ones, and the FSM state enumeration.
REQ-036 Sub-module fp_pack_word (combinational: sign/exp/mant/flag-select -> out_word) SHALL be instantiated once.

Verification
REQ-037 sign=0, exp=8'h81, mant=24'hC00000, carry=0 -> next cycle out_valid=1, out_word=32'h40C00000, flags 0.
REQ-038 exp=8'h80, mant=24'h800000, carry=1 -> latency 1, out_word=32'h40C00000.
REQ-039 exp=8'h85, mant=24'h000001, carry=0 -> 23 shifts, out_valid at cycle 24, out_word=32'h37000000.
REQ-040 sign=1, mant=0, carry=0 -> out_word=32'h00000000, out_zero=1; exp=8'hFE, carry=1 -> 32'h7F800000, out_ovf=1.
REQ-041 exp=8'h03, mant=24'h100000 -> underflow after 2 shifts, out_word=32'h00000000, out_unf=1; hold out_ready=0 3 cycles -> word stable, in_ready=0.
REQ-042 Assert rst_n=0 mid-SHIFT of REQ-039 case -> out_valid never pulses, in_ready=1 immediately, next input processed normally.
